// File: rtl/dmem_arbiter_if.sv
// Shared data-RAM port bundle: execute-stage requester, debug/loader requester and RAM side.
// The arbiter takes the slave view; whoever drives the requests and models the RAM takes the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic [31:0]       ex_addr;
  logic [3:0]        ex_rden;
  logic [3:0]        ex_wren;
  logic              ex_rden_sext;
  logic [31:0]       ex_wrdata;
  logic              ex_stall;
  logic              ex_rdata_vld;
  logic [31:0]       ex_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvld;
  logic [31:0]       dbg_rdata;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  ex_addr, ex_rden, ex_wren, ex_rden_sext, ex_wrdata,
    output ex_stall, ex_rdata_vld, ex_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvld, dbg_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output ex_addr, ex_rden, ex_wren, ex_rden_sext, ex_wrdata,
    input  ex_stall, ex_rdata_vld, ex_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvld, dbg_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the execute stage and a debug/loader port,
// with starvation forcing for debug and a one-cycle load-return path with lane extraction.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  // state  | meaning
  // IDLE   | no read data returning this cycle
  // RD_EX  | RAM word returning for an execute-stage load
  // RD_DBG | RAM word returning for a debug read
  typedef enum logic [1:0] {IDLE, RD_EX, RD_DBG} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_starve;
  logic [3:0]       r_rden;
  logic             r_sext;
  logic [31:0]      r_ex_hold;
  logic [31:0]      r_dbg_hold;

  logic        w_ex_act;
  logic        w_force;
  logic        w_dbg_issue;
  logic        w_ex_issue;
  logic        w_ex_rd;
  logic        w_dbg_rd;
  logic [31:0] w_ex_data;
  logic        w_unused;

  assign w_ex_act    = (|bus.ex_rden) || (|bus.ex_wren);
  assign w_force     = bus.dbg_req && (r_starve == CNT_MAX);
  assign w_dbg_issue = rst_n && bus.dbg_req && (w_force || !w_ex_act);
  assign w_ex_issue  = rst_n && w_ex_act && !w_dbg_issue;
  // A write mask on the EX side turns a combined request into a pure store.
  assign w_ex_rd     = w_ex_issue && (bus.ex_wren == 4'b0000);
  assign w_dbg_rd    = w_dbg_issue && !bus.dbg_we;

  assign bus.ex_stall  = rst_n && w_force && w_ex_act;
  assign bus.dbg_gnt   = w_dbg_issue;
  assign bus.ram_en    = w_ex_issue || w_dbg_issue;
  assign bus.ram_we    = w_dbg_issue ? {4{bus.dbg_we}} : (w_ex_issue ? bus.ex_wren : 4'b0000);
  assign bus.ram_addr  = w_dbg_issue ? bus.dbg_addr[ADDR_W+1:2] : bus.ex_addr[ADDR_W+1:2];
  assign bus.ram_wdata = w_dbg_issue ? bus.dbg_wdata : bus.ex_wrdata;

  assign w_unused = ^{bus.ex_addr[31:ADDR_W+2], bus.ex_addr[1:0],
                      bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};

  always_comb begin
    w_ex_data = bus.ram_rdata;
    case (r_rden)
      4'b0011: w_ex_data = {{16{r_sext & bus.ram_rdata[15]}}, bus.ram_rdata[15:0]};
      4'b1100: w_ex_data = {{16{r_sext & bus.ram_rdata[31]}}, bus.ram_rdata[31:16]};
      4'b0001: w_ex_data = {{24{r_sext & bus.ram_rdata[7]}},  bus.ram_rdata[7:0]};
      4'b0010: w_ex_data = {{24{r_sext & bus.ram_rdata[15]}}, bus.ram_rdata[15:8]};
      4'b0100: w_ex_data = {{24{r_sext & bus.ram_rdata[23]}}, bus.ram_rdata[23:16]};
      4'b1000: w_ex_data = {{24{r_sext & bus.ram_rdata[31]}}, bus.ram_rdata[31:24]};
      default: w_ex_data = bus.ram_rdata;
    endcase
  end

  // Return data passes straight through in the valid cycle and is held afterwards.
  assign bus.ex_rdata_vld = (r_state == RD_EX);
  assign bus.ex_rdata     = (r_state == RD_EX) ? w_ex_data : r_ex_hold;
  assign bus.dbg_rvld     = (r_state == RD_DBG);
  assign bus.dbg_rdata    = (r_state == RD_DBG) ? bus.ram_rdata : r_dbg_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_rden     <= 4'b0000;
      r_sext     <= 1'b0;
      r_ex_hold  <= 32'h0;
      r_dbg_hold <= 32'h0;
    end else begin
      if (r_state == RD_EX)  r_ex_hold  <= w_ex_data;
      if (r_state == RD_DBG) r_dbg_hold <= bus.ram_rdata;

      if (w_ex_rd) begin
        r_state <= RD_EX;
        r_rden  <= bus.ex_rden;
        r_sext  <= bus.ex_rden_sext;
      end else if (w_dbg_rd) begin
        r_state <= RD_DBG;
      end else begin
        r_state <= IDLE;
      end

      if (bus.dbg_req && w_ex_issue) begin
        if (r_starve != CNT_MAX) r_starve <= r_starve + CNT_W'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// behavioural model of the arbitration, starvation and load-return rules.
module tb_dmem_arbiter;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int          m_starve;
  int          m_pend;      // 0 nothing, 1 ex load returning, 2 debug read returning
  logic [3:0]  m_mask;
  logic        m_sext;
  logic [31:0] m_ex_hold;
  logic [31:0] m_dbg_hold;

  function automatic logic [31:0] model_load(logic [3:0] mask, logic sext, logic [31:0] raw);
    int lo, n;
    logic [31:0] keep, f;
    lo = -1; n = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) begin n++; if (lo < 0) lo = i; end
    if (n == 0 || n == 3 || n == 4) return raw;
    if (int'(mask) != (((1 << n) - 1) << lo)) return raw;
    if ((lo % n) != 0) return raw;
    keep = (32'h1 << (8 * n)) - 32'h1;
    f = (raw >> (8 * lo)) & keep;
    if (sext && f[8 * n - 1]) f = f | ~keep;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_addr = 32'h0; bus.ex_rden = 4'h0; bus.ex_wren = 4'h0;
    bus.ex_rden_sext = 1'b0; bus.ex_wrdata = 32'h0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0;
    bus.ram_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    m_starve = 0; m_pend = 0; m_mask = 4'h0; m_sext = 1'b0;
    m_ex_hold = 32'h0; m_dbg_hold = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ex_addr = 32'h0000_0040; bus.ex_rden = 4'hF; bus.ex_wren = 4'h3;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.ram_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", bus.ram_en); end
    checks++; if (bus.ram_we !== 4'h0) begin failures++; $display("FAIL reset_ram_we got=%h exp=0", bus.ram_we); end
    checks++; if (bus.dbg_gnt !== 1'b0) begin failures++; $display("FAIL reset_dbg_gnt got=%b exp=0", bus.dbg_gnt); end
    checks++; if (bus.ex_stall !== 1'b0) begin failures++; $display("FAIL reset_ex_stall got=%b exp=0", bus.ex_stall); end
    checks++; if (bus.ex_rdata_vld !== 1'b0 || bus.dbg_rvld !== 1'b0) begin failures++; $display("FAIL reset_valids got=%b%b exp=00", bus.ex_rdata_vld, bus.dbg_rvld); end
    checks++; if (bus.ex_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.ex_rdata, bus.dbg_rdata); end
    apply_reset();
  endtask

  task automatic test_loads();
    // signed byte load from the top lane
    bus.ex_addr = 32'h0000_0003; bus.ex_rden = 4'b1000; bus.ex_rden_sext = 1'b1;
    #2;
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 12'h000 || bus.ram_we !== 4'h0) begin failures++; $display("FAIL lb_issue got en=%b addr=%h we=%h exp 1/000/0", bus.ram_en, bus.ram_addr, bus.ram_we); end
    tick();
    idle_inputs(); bus.ram_rdata = 32'h80FF_FF00;
    #2;
    checks++; if (bus.ex_rdata_vld !== 1'b1 || bus.ex_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_return got vld=%b data=%h exp 1/ffffff80", bus.ex_rdata_vld, bus.ex_rdata); end
    tick();
    bus.ram_rdata = 32'h1234_5678;
    #2;
    checks++; if (bus.ex_rdata_vld !== 1'b0 || bus.ex_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_hold got vld=%b data=%h exp 0/ffffff80", bus.ex_rdata_vld, bus.ex_rdata); end
    tick();
    // unsigned halfword load from the upper half
    bus.ex_addr = 32'h0000_0002; bus.ex_rden = 4'b1100; bus.ex_rden_sext = 1'b0;
    tick();
    idle_inputs(); bus.ram_rdata = 32'h8001_1234;
    #2;
    checks++; if (bus.ex_rdata_vld !== 1'b1 || bus.ex_rdata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_return got vld=%b data=%h exp 1/00008001", bus.ex_rdata_vld, bus.ex_rdata); end
    tick();
    // combined read+write mask: store only
    bus.ex_addr = 32'h0000_0084; bus.ex_rden = 4'b1111; bus.ex_wren = 4'b0011; bus.ex_wrdata = 32'hA5A5_5A5A;
    #2;
    checks++; if (bus.ram_we !== 4'b0011 || bus.ram_addr !== 12'h021 || bus.ram_wdata !== 32'hA5A5_5A5A) begin failures++; $display("FAIL rw_both_issue got we=%h addr=%h wd=%h exp 3/021/a5a55a5a", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
    tick();
    idle_inputs(); bus.ram_rdata = 32'h7777_7777;
    #2;
    checks++; if (bus.ex_rdata_vld !== 1'b0) begin failures++; $display("FAIL rw_both_no_vld got=%b exp=0", bus.ex_rdata_vld); end
    tick();
  endtask

  task automatic test_dbg_read();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0000_0010;
    #2;
    checks++; if (bus.dbg_gnt !== 1'b1 || bus.ram_addr !== 12'h004 || bus.ram_we !== 4'h0 || bus.ram_en !== 1'b1) begin failures++; $display("FAIL dbg_issue got gnt=%b addr=%h we=%h en=%b exp 1/004/0/1", bus.dbg_gnt, bus.ram_addr, bus.ram_we, bus.ram_en); end
    tick();
    idle_inputs(); bus.ram_rdata = 32'hC0DE_F00D;
    #2;
    checks++; if (bus.dbg_rvld !== 1'b1 || bus.dbg_rdata !== 32'hC0DE_F00D || bus.ex_rdata_vld !== 1'b0) begin failures++; $display("FAIL dbg_return got rvld=%b data=%h exvld=%b exp 1/c0def00d/0", bus.dbg_rvld, bus.dbg_rdata, bus.ex_rdata_vld); end
    tick();
    bus.ram_rdata = 32'h0;
    #2;
    checks++; if (bus.dbg_rvld !== 1'b0 || bus.dbg_rdata !== 32'hC0DE_F00D) begin failures++; $display("FAIL dbg_hold got rvld=%b data=%h exp 0/c0def00d", bus.dbg_rvld, bus.dbg_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      bus.ex_addr = 32'h0000_0100; bus.ex_wren = 4'b0011; bus.ex_wrdata = 32'h1111_2222;
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h0000_0020; bus.dbg_wdata = 32'h3333_4444;
      #2;
      checks++;
      if (bus.dbg_gnt !== (c == STARVE_MAX) || bus.ex_stall !== (c == STARVE_MAX)) begin
        failures++; $display("FAIL starve_gnt cycle=%0d got gnt=%b stall=%b exp=%b", c, bus.dbg_gnt, bus.ex_stall, c == STARVE_MAX);
      end
      checks++;
      if (bus.ram_addr !== ((c == STARVE_MAX) ? 12'h008 : 12'h040) || bus.ram_we !== ((c == STARVE_MAX) ? 4'hF : 4'h3)) begin
        failures++; $display("FAIL starve_ram cycle=%0d got addr=%h we=%h", c, bus.ram_addr, bus.ram_we);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_flight();
    apply_reset();
    bus.ex_addr = 32'h0000_0008; bus.ex_rden = 4'hF;
    #2;
    checks++; if (bus.ram_en !== 1'b1) begin failures++; $display("FAIL inflight_issue got en=%b exp=1", bus.ram_en); end
    rst_n = 1'b0;
    tick();
    bus.ram_rdata = 32'h5555_AAAA;
    #2;
    checks++; if (bus.ex_rdata_vld !== 1'b0 || bus.ram_en !== 1'b0 || bus.ex_rdata !== 32'h0) begin failures++; $display("FAIL inflight_reset got vld=%b en=%b data=%h exp 0/0/0", bus.ex_rdata_vld, bus.ram_en, bus.ex_rdata); end
    idle_inputs(); rst_n = 1'b1;
    tick();
    #2;
    checks++; if (bus.ex_rdata_vld !== 1'b0) begin failures++; $display("FAIL inflight_after got vld=%b exp=0", bus.ex_rdata_vld); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] masks [9];
    logic ex_act, forced, dbg_wins, ex_wins;
    logic [3:0] exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] exp_wd, exp_ex;
    masks = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h6};
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.ex_rden      = masks[$urandom_range(0, 8)];
      if (bus.ex_rden == 4'h6) bus.ex_rden = 4'($urandom_range(0, 15));
      bus.ex_wren      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      bus.ex_rden_sext = 1'($urandom_range(0, 1));
      bus.ex_addr      = $urandom;
      bus.ex_wrdata    = $urandom;
      bus.dbg_req      = ($urandom_range(0, 3) != 0);
      bus.dbg_we       = 1'($urandom_range(0, 1));
      bus.dbg_addr     = $urandom;
      bus.dbg_wdata    = $urandom;
      bus.ram_rdata    = $urandom;
      #2;
      ex_act   = (bus.ex_rden != 0) || (bus.ex_wren != 0);
      forced   = bus.dbg_req && (m_starve == STARVE_MAX);
      dbg_wins = bus.dbg_req && (forced || !ex_act);
      ex_wins  = ex_act && !dbg_wins;
      exp_we   = dbg_wins ? (bus.dbg_we ? 4'hF : 4'h0) : (ex_wins ? bus.ex_wren : 4'h0);
      exp_addr = ADDR_W'((dbg_wins ? bus.dbg_addr : bus.ex_addr) >> 2);
      exp_wd   = dbg_wins ? bus.dbg_wdata : bus.ex_wrdata;
      checks++; if (bus.dbg_gnt !== dbg_wins || bus.ex_stall !== (forced && ex_act)) begin failures++; $display("FAIL rnd_arb n=%0d got gnt=%b stall=%b exp %b/%b", n, bus.dbg_gnt, bus.ex_stall, dbg_wins, forced && ex_act); end
      checks++; if (bus.ram_en !== (dbg_wins || ex_wins) || bus.ram_we !== exp_we) begin failures++; $display("FAIL rnd_ram_ctl n=%0d got en=%b we=%h exp %b/%h", n, bus.ram_en, bus.ram_we, dbg_wins || ex_wins, exp_we); end
      if (dbg_wins || ex_wins) begin
        checks++; if (bus.ram_addr !== exp_addr || bus.ram_wdata !== exp_wd) begin failures++; $display("FAIL rnd_ram_data n=%0d got addr=%h wd=%h exp %h/%h", n, bus.ram_addr, bus.ram_wdata, exp_addr, exp_wd); end
      end
      if (m_pend == 1) m_ex_hold = model_load(m_mask, m_sext, bus.ram_rdata);
      if (m_pend == 2) m_dbg_hold = bus.ram_rdata;
      exp_ex = m_ex_hold;
      checks++; if (bus.ex_rdata_vld !== (m_pend == 1) || bus.ex_rdata !== exp_ex) begin failures++; $display("FAIL rnd_ex_ret n=%0d got vld=%b data=%h exp %b/%h", n, bus.ex_rdata_vld, bus.ex_rdata, m_pend == 1, exp_ex); end
      checks++; if (bus.dbg_rvld !== (m_pend == 2) || bus.dbg_rdata !== m_dbg_hold) begin failures++; $display("FAIL rnd_dbg_ret n=%0d got vld=%b data=%h exp %b/%h", n, bus.dbg_rvld, bus.dbg_rdata, m_pend == 2, m_dbg_hold); end
      m_pend = 0;
      if (ex_wins && bus.ex_wren == 0) begin m_pend = 1; m_mask = bus.ex_rden; m_sext = bus.ex_rden_sext; end
      if (dbg_wins && !bus.dbg_we) m_pend = 2;
      if (bus.dbg_req && ex_wins) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else m_starve = 0;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_starve = 0; m_pend = 0; m_mask = 4'h0; m_sext = 1'b0;
    m_ex_hold = 32'h0; m_dbg_hold = 32'h0;
    test_reset();
    test_loads();
    test_dbg_read();
    test_starvation();
    test_reset_in_flight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
